// File: rtl/bit_timer_ctrl.sv
// bit_timer_ctrl
//   Bit-timing sequencer for a serial receiver. It drives one external
//   flex-counter period timer (clear / enable / rollover value) and reacts
//   to the timer's rollover flag. The first data bit is sampled half a bit
//   period into the frame; every later bit follows one full period after
//   the previous one. One shift strobe is emitted per data bit.
//
//   Optional build: define BIT_TIMER_STOP_CHECK_EN to add a stop-bit sample
//   (STOP state, line_in input, frame_err output).
//
//   Start handshake: start is taken only while busy = 0 and the state is
//   IDLE. busy stays high from the cycle after an accepted start until the
//   cycle in which exactly one of done / aborted pulses. A start with an
//   invalid config answers with a one-cycle cfg_err pulse and busy stays low.
//
// Ports
//   clk, n_rst        clock, synchronous active-low reset
//   start, abort      frame request / cancel
//   cfg_period        clocks per bit (>= 2), latched at start
//   cfg_bits          data bits per frame (>= 1), latched at start
//   per_flag          timer rollover flag
//   per_clear         timer clear
//   per_enable        timer count enable
//   per_rollover_val  timer rollover value
//   shift_strobe      one pulse per data bit (mid-bit)
//   busy              frame in progress
//   done              one-cycle pulse, frame completed
//   cfg_err           one-cycle pulse, start refused (bad config)
//   aborted           one-cycle pulse, frame cancelled
//   dbg_state         current FSM state encoding
//   line_in           serial line, stop-bit sample (optional build)
//   frame_err         one-cycle pulse with done, stop bit was 0 (optional build)
module bit_timer_ctrl #(
   parameter int PER_BITS = 8,
   parameter int BIT_BITS = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic                abort,
   input  logic [PER_BITS-1:0] cfg_period,
   input  logic [BIT_BITS-1:0] cfg_bits,
   input  logic                per_flag,
`ifdef BIT_TIMER_STOP_CHECK_EN
   input  logic                line_in,
   output logic                frame_err,
`endif
   output logic                per_clear,
   output logic                per_enable,
   output logic [PER_BITS-1:0] per_rollover_val,
   output logic                shift_strobe,
   output logic                busy,
   output logic                done,
   output logic                cfg_err,
   output logic                aborted,
   output logic [2:0]          dbg_state
);

`ifdef BIT_TIMER_STOP_CHECK_EN
   typedef enum logic [2:0] {IDLE, ALIGN, RUN, DONE, STOP} state_t;
   localparam state_t AFTER_LAST = STOP;
`else
   typedef enum logic [2:0] {IDLE, ALIGN, RUN, DONE} state_t;
   localparam state_t AFTER_LAST = DONE;
`endif

   state_t              state_q, state_d;
   logic [PER_BITS-1:0] period_q, period_d;
   logic [BIT_BITS-1:0] bits_q, bits_d;
   logic [BIT_BITS-1:0] bit_cnt_q, bit_cnt_d;
   logic                done_d, cfg_err_d, aborted_d;
   logic                cfg_ok;
   logic                last_bit;
`ifdef BIT_TIMER_STOP_CHECK_EN
   logic                stop_bit_q, stop_bit_d;
   logic                frame_err_d;
`endif

   assign dbg_state = state_q;
   assign cfg_ok    = (cfg_period > PER_BITS'(1)) && (cfg_bits != '0);
   // bits_q never exceeds 2^BIT_BITS-1, so the +1 cannot wrap before it matches.
   assign last_bit  = (BIT_BITS'(bit_cnt_q + 1'b1) == bits_q);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         period_q   <= '0;
         bits_q     <= '0;
         bit_cnt_q  <= '0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         aborted    <= 1'b0;
`ifdef BIT_TIMER_STOP_CHECK_EN
         stop_bit_q <= 1'b1;
         frame_err  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         bits_q     <= bits_d;
         bit_cnt_q  <= bit_cnt_d;
         done       <= done_d;
         cfg_err    <= cfg_err_d;
         aborted    <= aborted_d;
`ifdef BIT_TIMER_STOP_CHECK_EN
         stop_bit_q <= stop_bit_d;
         frame_err  <= frame_err_d;
`endif
      end
   end

   always_comb begin
      state_d          = state_q;
      period_d         = period_q;
      bits_d           = bits_q;
      bit_cnt_d        = bit_cnt_q;
      done_d           = 1'b0;
      cfg_err_d        = 1'b0;
      aborted_d        = 1'b0;
      per_clear        = 1'b0;
      per_enable       = 1'b0;
      per_rollover_val = '0;
      shift_strobe     = 1'b0;
      busy             = 1'b0;
`ifdef BIT_TIMER_STOP_CHECK_EN
      stop_bit_d       = stop_bit_q;
      frame_err_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            per_clear = 1'b1;
            // abort outranks start even though abort alone does nothing here
            if (start && !abort) begin
               if (cfg_ok) begin
                  period_d  = cfg_period;
                  bits_d    = cfg_bits;
                  bit_cnt_d = '0;
                  state_d   = ALIGN;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ALIGN: begin
            busy             = 1'b1;
            per_enable       = 1'b1;
            per_rollover_val = period_q >> 1;
            // half-bit reached: sample, and restart the timer for full periods
            shift_strobe     = per_flag;
            per_clear        = per_flag;
            if (abort) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (per_flag) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               state_d   = (bits_q == BIT_BITS'(1)) ? AFTER_LAST : RUN;
            end
         end
         RUN: begin
            busy             = 1'b1;
            per_enable       = 1'b1;
            per_rollover_val = period_q;
            shift_strobe     = per_flag;
            if (abort) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (per_flag) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (last_bit) state_d = AFTER_LAST;
            end
         end
`ifdef BIT_TIMER_STOP_CHECK_EN
         STOP: begin
            busy             = 1'b1;
            per_enable       = 1'b1;
            per_rollover_val = period_q;
            if (abort) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (per_flag) begin
               stop_bit_d = line_in;
               state_d    = DONE;
            end
         end
`endif
         DONE: begin
            busy             = 1'b1;
            per_clear        = 1'b1;
            per_rollover_val = period_q;
            state_d          = IDLE;
            if (abort) begin
               aborted_d = 1'b1;
            end else begin
               done_d = 1'b1;
`ifdef BIT_TIMER_STOP_CHECK_EN
               frame_err_d = !stop_bit_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bit_timer_ctrl.sv
// Directed bench for bit_timer_ctrl. A small flex-timer model closes the
// per_* loop: clear restarts the period (a cleared-while-enabled cycle counts
// as the first tick), and the flag is high while the count sits on the
// rollover value. Expected strobe cycles are derived from the frame config.
module tb_bit_timer_ctrl;
   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] cfg_period = 8'd0;
   logic [3:0] cfg_bits = 4'd0;
   logic       per_flag;
   logic       per_clear, per_enable, shift_strobe, busy, done, cfg_err, aborted;
   logic [7:0] per_rollover_val;
   logic [2:0] dbg_state;
`ifdef BIT_TIMER_STOP_CHECK_EN
   logic       line_in = 1'b1;
   logic       frame_err;
`endif

   int         n_vec = 0;
   int         n_err = 0;
   logic [15:0] exp_q[$];

   bit_timer_ctrl #(.PER_BITS(8), .BIT_BITS(4)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
      .cfg_period(cfg_period), .cfg_bits(cfg_bits), .per_flag(per_flag),
`ifdef BIT_TIMER_STOP_CHECK_EN
      .line_in(line_in), .frame_err(frame_err),
`endif
      .per_clear(per_clear), .per_enable(per_enable),
      .per_rollover_val(per_rollover_val), .shift_strobe(shift_strobe),
      .busy(busy), .done(done), .cfg_err(cfg_err), .aborted(aborted),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // flex-timer model
   logic [7:0] tmr_cnt;
   always_ff @(posedge clk) begin
      if (per_clear)       tmr_cnt <= per_enable ? 8'd1 : 8'd0;
      else if (per_enable) tmr_cnt <= (tmr_cnt == per_rollover_val) ? 8'd1 : tmr_cnt + 8'd1;
   end
   assign per_flag = per_enable && (tmr_cnt == per_rollover_val);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one frame from the start pulse; abort_at < 0 means no abort,
   // otherwise abort is held during cycle abort_at (cycles counted from
   // ALIGN entry). line_val is the stop-bit level (optional build only).
   task automatic run_frame(input int period, input int bits, input int abort_at, input logic line_val);
      int last_t;
      int end_t;
      last_t = 4;
      exp_q.delete();
      for (int i = 0; i < bits; i++) begin
         last_t = (period / 2) + period * i;
         if (abort_at < 0 || last_t <= abort_at) exp_q.push_back(16'(last_t));
      end
`ifdef BIT_TIMER_STOP_CHECK_EN
      line_in = line_val;
      end_t = last_t + period + 2;
`else
      end_t = last_t + 2;
      if (line_val) end_t = last_t + 2;
`endif
      if (abort_at >= 0) end_t = abort_at + 1;

      cfg_period = 8'(period);
      cfg_bits   = 4'(bits);
      start      = 1'b1;
      tick();
      start      = 1'b0;
      cfg_period = 8'd1;   // later config changes must not matter
      cfg_bits   = 4'd0;
      check("align_busy", busy, 1);
      check("align_enable", per_enable, 1);
      check("align_rollover", per_rollover_val, 32'(period / 2));

      for (int t = 0; t < end_t; t++) begin
         if (t == abort_at) abort = 1'b1;
         if (t == 1) begin
            start = 1'b1;   // ignored while busy
         end
         if (shift_strobe) begin
            if (exp_q.size() != 0) check("strobe_cycle", 32'(t), 32'(exp_q.pop_front()));
            else                   check("spurious_strobe", shift_strobe, 0);
         end
         if (t == period / 2) check("align_exit_clear", per_clear, 1);
         if (bits > 1 && t == period / 2 + 2) begin
            check("run_rollover", per_rollover_val, 32'(period));
            check("run_clear", per_clear, 0);
         end
         if (abort_at < 0 && t == end_t - 1) begin
            check("done_state_busy", busy, 1);
            check("done_state_enable", per_enable, 0);
            check("done_state_clear", per_clear, 1);
         end
         if (done || aborted) check("early_end", {done, aborted}, 0);
         tick();
         start = 1'b0;
         abort = 1'b0;
      end

      if (abort_at >= 0) begin
         check("aborted_pulse", aborted, 1);
         check("no_done_on_abort", done, 0);
      end else begin
         check("done_pulse", done, 1);
         check("aborted_quiet", aborted, 0);
`ifdef BIT_TIMER_STOP_CHECK_EN
         check("frame_err", frame_err, !line_val);
`endif
      end
      check("busy_low_at_end", busy, 0);
      check("missing_strobes", 32'(exp_q.size()), 0);
      tick();
      check("pulse_one_cycle", {done, aborted}, 0);
   endtask

   initial begin
      // reset
      n_rst = 1'b0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_clear", per_clear, 1);
      check("rst_enable", per_enable, 0);
      check("rst_rollover", per_rollover_val, 0);
      check("rst_pulses", {shift_strobe, done, cfg_err, aborted}, 0);
      check("rst_state", dbg_state, 0);
      n_rst = 1'b1;
      tick();

      // normal frame 8/8
      run_frame(8, 8, -1, 1'b1);

      // config rejection
      cfg_period = 8'd1; cfg_bits = 4'd8; start = 1'b1;
      tick();
      start = 1'b0;
      check("cfg_err_period", cfg_err, 1);
      check("cfg_err_period_busy", busy, 0);
      check("cfg_err_period_strobe", shift_strobe, 0);
      tick();
      check("cfg_err_one_cycle", cfg_err, 0);
      cfg_period = 8'd8; cfg_bits = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("cfg_err_bits", cfg_err, 1);
      check("cfg_err_bits_busy", busy, 0);
      tick();

      // abort in IDLE, and abort together with start
      abort = 1'b1;
      tick();
      check("idle_abort_quiet", aborted, 0);
      cfg_period = 8'd8; cfg_bits = 4'd8; start = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("abort_beats_start", busy, 0);
      check("abort_beats_start_pulse", aborted, 0);
      tick();

      // single bit, odd period
      run_frame(9, 1, -1, 1'b1);

      // abort mid-RUN after 3 strobes, then a full frame
      run_frame(8, 8, 24, 1'b1);
      run_frame(8, 8, -1, 1'b1);

      // short period, long frame
      run_frame(2, 15, -1, 1'b1);

`ifdef BIT_TIMER_STOP_CHECK_EN
      // stop bit low -> frame_err with done
      run_frame(8, 3, -1, 1'b0);
      run_frame(8, 3, -1, 1'b1);
`endif

      // reset mid-frame
      cfg_period = 8'd8; cfg_bits = 4'd8; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      check("pre_reset_busy", busy, 1);
      n_rst = 1'b0;
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_clear", per_clear, 1);
      check("midrst_pulses", {shift_strobe, done, aborted}, 0);
      n_rst = 1'b1;
      tick();
      check("midrst_no_done", {done, aborted, busy}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
